alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Generalised data width, 4-bit opcode space adding unsigned compare, shifts and an iterative shift-add multiply.
- Registered flag outputs (zero, carry, overflow) and a valid/ready handshake on both sides.
- Sits between the register-file read stage and writeback in the multi-cycle CPU datapath.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides and an iterative shift-add multiplier.
// Single-cycle ops complete in one cycle; MUL takes WIDTH+1 cycles from accept to out_valid.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpNand = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpNor  = 4'd4;
    localparam logic [3:0] OpOr   = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpSlt  = 4'd7;
    localparam logic [3:0] OpSltu = 4'd8;
    localparam logic [3:0] OpSll  = 4'd9;
    localparam logic [3:0] OpSrl  = 4'd10;
    localparam logic [3:0] OpSra  = 4'd11;
    localparam logic [3:0] OpMul  = 4'd12;

    localparam logic [SHW:0] CntInit = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CntOne  = (SHW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW:0]     cnt_q, cnt_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    assign add_full = {1'b0, A} + {1'b0, B};
    assign diff     = A - B;
    assign shamt    = B[SHW-1:0];

    // Single-cycle datapath; MUL and illegal opcodes fall to the zero default.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (command)
            OpAdd: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            OpSub: begin
                alu_res   = diff;
                alu_carry = (A >= B);
                alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OpNand: alu_res = ~(A & B);
            OpAnd:  alu_res = A & B;
            OpNor:  alu_res = ~(A | B);
            OpOr:   alu_res = A | B;
            OpXor:  alu_res = A ^ B;
            OpSlt:  alu_res = {{(WIDTH - 1){1'b0}}, ($signed(A) < $signed(B))};
            OpSltu: alu_res = {{(WIDTH - 1){1'b0}}, (A < B)};
            OpSll:  alu_res = A << shamt;
            OpSrl:  alu_res = A >> shamt;
            OpSra:  alu_res = WIDTH'($signed(A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (command == OpMul) begin
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = CntInit;
                        state_d  = StBusy;
                    end else begin
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        carry_d    = alu_carry;
                        overflow_d = alu_ovf;
                        state_d    = StDone;
                    end
                end
            end
            StBusy: begin
                // Counter hits zero after WIDTH steps; the extra cycle registers the product.
                if (cnt_q == '0) begin
                    result_d   = acc_q;
                    zero_d     = (acc_q == '0);
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = StDone;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CntOne;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32): single-cycle ops, MUL latency,
// backpressure hold, mid-MUL reset and illegal opcodes.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  command;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one single-cycle op, check outputs one cycle later, then retire it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] cmd, input logic [31:0] exp_res,
                          input logic exp_z, input logic exp_c, input logic exp_o);
        A        = a;
        B        = b;
        command  = cmd;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        A        = 32'hDEAD_BEEF;
        B        = 32'h1234_5678;
        command  = 4'd0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"}, {29'd0, zero, carry, overflow}, {29'd0, exp_z, exp_c, exp_o});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_retired"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int n;
        int busy_low;
        int stable;
        logic [31:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        command   = '0;
        tick();
        chk("reset_result", result, 32'd0);
        chk("reset_ctrl", {28'd0, out_valid, zero, carry, overflow}, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        run_op("add_ovf",  32'h7FFF_FFFF, 32'd1, 4'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        run_op("add_cry",  32'hFFFF_FFFF, 32'd1, 4'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_eq",   32'd5,         32'd5, 4'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_brw",  32'd1,         32'd2, 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  32'h8000_0000, 32'd1, 4'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        run_op("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
        run_op("and",  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        run_op("nor",  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
        run_op("or",   32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        run_op("xor",  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        run_op("slt",  32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op("sltu", 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("sra",  32'h8000_0000, 32'h24, 4'd11, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        run_op("srl",  32'h8000_0000, 32'h24, 4'd10, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        run_op("sll",  32'h0000_0001, 32'h24, 4'd9,  32'h0000_0010, 1'b0, 1'b0, 1'b0);

        // MUL -3 * 7 with operands scrambled while busy.
        A        = 32'hFFFF_FFFD;
        B        = 32'd7;
        command  = 4'd12;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n        = 0;
        busy_low = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) busy_low++;
            A       = 32'h5555_0000 + 32'(n);
            B       = 32'hAAAA_0000 - 32'(n);
            command = 4'd0;
            tick();
            n++;
        end
        chk("mul_latency", 32'(n), 32'd33);
        chk("mul_busy_in_ready", 32'(busy_low), 32'd33);
        chk("mul_result", result, 32'hFFFF_FFEB);
        chk("mul_flags", {29'd0, zero, carry, overflow}, 32'd0);

        // Backpressure: hold 10 cycles with a competing request that must be ignored.
        held     = result;
        stable   = 0;
        A        = 32'd100;
        B        = 32'd200;
        command  = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid && !in_ready && result == 32'hFFFF_FFEB && !zero && !carry && !overflow)
                stable++;
        end
        chk("bp_stable_cycles", 32'(stable), 32'd10);
        chk("bp_result_held", result, held);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
        tick();
        chk("bp_no_accept", {30'd0, out_valid, in_ready}, 32'b01);
        chk("bp_result_kept", result, 32'hFFFF_FFEB);

        // Reset during BUSY cycle 12.
        A        = 32'd5;
        B        = 32'd6;
        command  = 4'd12;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk("pre_reset_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #2;
        chk("mid_reset_ctrl", {27'd0, out_valid, in_ready, zero, carry, overflow}, 32'b01000);
        chk("mid_reset_result", result, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_ctrl", {30'd0, out_valid, in_ready}, 32'b01);
        chk("post_reset_result", result, 32'd0);

        run_op("add_after_rst", 32'd2, 32'd3, 4'd0, 32'd5, 1'b0, 1'b0, 1'b0);
        run_op("illegal14", 32'hFFFF_FFFF, 32'd1, 4'd14, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("illegal15", 32'h7FFF_FFFF, 32'd1, 4'd15, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
